// File: rtl/octave_pkg.sv
// octave_pkg: shared types and default constants for the octave selector slice
package octave_pkg;
   typedef enum logic {LED_BINARY = 1'b0, LED_THERM = 1'b1} led_mode_e;
   localparam int TICK_DIV_DEF = 9375000;
   localparam int MIN_OCT_DEF  = 1;
   localparam int MAX_OCT_DEF  = 5;
   localparam int DEF_OCT_DEF  = 1;
endpackage

// File: rtl/octave_selector_if.sv
// octave_selector_if: button/display bundle between board I/O and the octave selector
interface octave_selector_if #(
   parameter int OCT_W = 8,
   parameter int LED_W = 8
);
   logic             key_up_n;
   logic             key_dn_n;
   logic             led_mode;
   logic [OCT_W-1:0] octave;
   logic [LED_W-1:0] led;
   logic             changed;
   logic             at_limit;
   modport master (output key_up_n, key_dn_n, led_mode, input octave, led, changed, at_limit);
   modport slave  (input key_up_n, key_dn_n, led_mode, output octave, led, changed, at_limit);
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: sync, tick-sampled debounce, press detect and auto-repeat for one active-low key
module key_conditioner #(
   parameter int DEBOUNCE_N   = 2,
   parameter int REPEAT_TICKS = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   input  logic tick,
   output logic step,
   output logic held
);
   localparam int DW = $clog2(DEBOUNCE_N + 1);
   localparam int RW = (REPEAT_TICKS < 2) ? 1 : $clog2(REPEAT_TICKS + 1);
   logic [1:0]    sync_q, sync_d;
   logic          db_q, db_d;
   logic [DW-1:0] run_q, run_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          sample;
   always_comb begin
      sync_d = {sync_q[0], key_n};
      sample = ~sync_q[1];
      db_d   = db_q;
      run_d  = run_q;
      rep_d  = rep_q;
      step   = 1'b0;
      if (tick) begin
         if (sample == db_q) run_d = '0;
         else if (32'(run_q) + 1 >= DEBOUNCE_N) begin
            db_d  = sample;
            run_d = '0;
         end else run_d = run_q + 1'b1;
         // press or release restarts the repeat interval; only a press steps
         if (!db_d || !db_q) begin
            rep_d = '0;
            step  = db_d;
         end else if (REPEAT_TICKS > 0) begin
            step  = 32'(rep_q) + 1 >= REPEAT_TICKS;
            rep_d = step ? '0 : rep_q + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '1;
         db_q   <= 1'b0;
         run_q  <= '0;
         rep_q  <= '0;
      end else begin
         sync_q <= sync_d;
         db_q   <= db_d;
         run_q  <= run_d;
         rep_q  <= rep_d;
      end
   end
   assign held = db_q;
endmodule

// File: rtl/octave_selector.sv
// octave_selector: two conditioned keys step a bounded octave register (wrap or saturate)
// and drive a registered binary/thermometer LED view of it
module octave_selector
   import octave_pkg::*;
#(
   parameter int TICK_DIV     = TICK_DIV_DEF,
   parameter int DEBOUNCE_N   = 2,
   parameter int REPEAT_TICKS = 4,
   parameter int MIN_OCT      = MIN_OCT_DEF,
   parameter int MAX_OCT      = MAX_OCT_DEF,
   parameter int DEF_OCT      = DEF_OCT_DEF,
   parameter int WRAP         = 1,
   parameter int OCT_W        = 8,
   parameter int LED_W        = 8
) (
   input logic              clk,
   input logic              reset_n,
   octave_selector_if.slave bus
);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [OCT_W-1:0] MIN_V = OCT_W'(MIN_OCT);
   localparam logic [OCT_W-1:0] MAX_V = OCT_W'(MAX_OCT);
   localparam logic [OCT_W-1:0] DEF_V = OCT_W'(DEF_OCT);
   if (MIN_OCT > DEF_OCT || DEF_OCT > MAX_OCT) begin : g_bad_def
      $error("octave_selector: need MIN_OCT <= DEF_OCT <= MAX_OCT");
   end
   if (OCT_W < 31 && MAX_OCT >= (1 << OCT_W)) begin : g_bad_width
      $error("octave_selector: MAX_OCT does not fit in OCT_W");
   end
   if (TICK_DIV < 2 || DEBOUNCE_N < 1) begin : g_bad_timing
      $error("octave_selector: need TICK_DIV >= 2 and DEBOUNCE_N >= 1");
   end
   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   logic             tick, up_step, dn_step, up_held, dn_held, up_go, dn_go, dual;
   logic             sup_up_q, sup_up_d, sup_dn_q, sup_dn_d;
   logic [OCT_W-1:0] octave_q, octave_d;
   logic [LED_W-1:0] led_q, led_d, therm;
   logic             changed_q, changed_d;
   assign tick = tick_cnt_q == TW'(TICK_DIV - 1);
   key_conditioner #(.DEBOUNCE_N(DEBOUNCE_N), .REPEAT_TICKS(REPEAT_TICKS)) u_up (
      .clk(clk), .reset_n(reset_n), .key_n(bus.key_up_n), .tick(tick), .step(up_step), .held(up_held)
   );
   key_conditioner #(.DEBOUNCE_N(DEBOUNCE_N), .REPEAT_TICKS(REPEAT_TICKS)) u_dn (
      .clk(clk), .reset_n(reset_n), .key_n(bus.key_dn_n), .tick(tick), .step(dn_step), .held(dn_held)
   );
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      // after a dual press a key stays muted until released; a fresh press needs a release first
      up_go      = up_step & ~sup_up_q;
      dn_go      = dn_step & ~sup_dn_q;
      dual       = up_go & dn_go;
      sup_up_d   = dual | (sup_up_q & up_held);
      sup_dn_d   = dual | (sup_dn_q & dn_held);
      octave_d   = dual  ? DEF_V
                 : up_go ? ((octave_q == MAX_V) ? ((WRAP != 0) ? MIN_V : octave_q) : octave_q + 1'b1)
                 : dn_go ? ((octave_q == MIN_V) ? ((WRAP != 0) ? MAX_V : octave_q) : octave_q - 1'b1)
                 : octave_q;
      changed_d  = octave_d != octave_q;
      therm      = '0;
      for (int i = 0; i < LED_W; i++) therm[i] = 32'(octave_q) > i;
      led_d      = (led_mode_e'(bus.led_mode) == LED_THERM) ? therm : LED_W'(octave_q);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_cnt_q <= '0;
         sup_up_q   <= 1'b0;
         sup_dn_q   <= 1'b0;
         octave_q   <= DEF_V;
         led_q      <= '0;
         changed_q  <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         sup_up_q   <= sup_up_d;
         sup_dn_q   <= sup_dn_d;
         octave_q   <= octave_d;
         led_q      <= led_d;
         changed_q  <= changed_d;
      end
   end
   assign bus.octave   = octave_q;
   assign bus.led      = led_q;
   assign bus.changed  = changed_q;
   assign bus.at_limit = (octave_q == MIN_V) || (octave_q == MAX_V);
endmodule
